// File: rtl/serial_tl_host_bridge.sv
// Host-side endpoint of the 1-bit serial TileLink link.
// Serializes host words onto the chip's input lane and deserializes the
// chip's output lane into words. Each direction runs at one bit per cycle.
module serial_tl_host_bridge #(
  parameter int unsigned W = 32
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_bits,
  output logic         ser_out_valid,
  input  logic         ser_out_ready,
  output logic         ser_out_bits,
  input  logic         ser_in_valid,
  output logic         ser_in_ready,
  input  logic         ser_in_bits,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_bits,
  output logic         tx_busy,
  output logic         rx_partial
);

  localparam int unsigned CW = $clog2(W + 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(W);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic [W-1:0]  tx_sr_q, tx_sr_d;
  logic [CW-1:0] tx_cnt_q, tx_cnt_d;
  logic [W-1:0]  rx_sr_q, rx_sr_d;
  logic [CW-1:0] rx_cnt_q, rx_cnt_d;
  logic [W-1:0]  out_bits_q, out_bits_d;
  logic          out_valid_q, out_valid_d;

  logic in_fire, ser_out_fire, ser_in_fire, out_fire;
  logic rx_full, load;

  // Handshake decode; reload on the last bit keeps TX words gapless.
  assign in_ready      = (tx_cnt_q == '0) || ((tx_cnt_q == CNT_ONE) && ser_out_ready);
  assign ser_out_valid = (tx_cnt_q != '0);
  assign ser_out_bits  = tx_sr_q[0];
  assign in_fire       = in_valid && in_ready;
  assign ser_out_fire  = ser_out_valid && ser_out_ready;

  assign rx_full       = (rx_cnt_q == CNT_FULL);
  assign load          = rx_full && (!out_valid_q || out_ready);
  assign ser_in_ready  = !rx_full || load;
  assign ser_in_fire   = ser_in_valid && ser_in_ready;
  assign out_fire      = out_valid_q && out_ready;

  assign out_valid     = out_valid_q;
  assign out_bits      = out_bits_q;
  assign tx_busy       = (tx_cnt_q != '0);
  assign rx_partial    = (rx_cnt_q != '0) && !rx_full;

  // TX shifter: a new word load wins over a shift in the same cycle.
  always_comb begin
    tx_sr_d  = tx_sr_q;
    tx_cnt_d = tx_cnt_q;
    if (in_fire) begin
      tx_sr_d  = in_bits;
      tx_cnt_d = CNT_FULL;
    end else if (ser_out_fire) begin
      tx_sr_d  = tx_sr_q >> 1;
      tx_cnt_d = tx_cnt_q - CNT_ONE;
    end
  end

  // RX assembler and holding register; a full shifter stalls the lane until it can load.
  always_comb begin
    rx_sr_d     = rx_sr_q;
    rx_cnt_d    = rx_cnt_q;
    out_bits_d  = out_bits_q;
    out_valid_d = out_valid_q;
    if (ser_in_fire) begin
      rx_sr_d = {ser_in_bits, rx_sr_q[W-1:1]};
    end
    if (load) begin
      rx_cnt_d    = ser_in_fire ? CNT_ONE : '0;
      out_bits_d  = rx_sr_q;
      out_valid_d = 1'b1;
    end else begin
      if (ser_in_fire) begin
        rx_cnt_d = rx_cnt_q + CNT_ONE;
      end
      if (out_fire) begin
        out_valid_d = 1'b0;
      end
    end
  end

  // State registers; reset discards any partial word in either direction.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      tx_sr_q     <= '0;
      tx_cnt_q    <= '0;
      rx_sr_q     <= '0;
      rx_cnt_q    <= '0;
      out_bits_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      tx_sr_q     <= tx_sr_d;
      tx_cnt_q    <= tx_cnt_d;
      rx_sr_q     <= rx_sr_d;
      rx_cnt_q    <= rx_cnt_d;
      out_bits_q  <= out_bits_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule
